// File: rtl/exc_commit_pkg.sv
// Shared CPU definitions for exception commit and CSR: ecodes, flag bit indices, commit FSM.
package exc_commit_pkg;

    // Bit positions inside the per-instruction exception flag vector.
    localparam int unsigned ExcW    = 5;
    localparam int unsigned ExcAdef = 0;
    localparam int unsigned ExcIne  = 1;
    localparam int unsigned ExcSys  = 2;
    localparam int unsigned ExcBrk  = 3;
    localparam int unsigned ExcAle  = 4;

    // Exception codes written to ESTAT.
    localparam logic [5:0] EcodeInt  = 6'h00;
    localparam logic [5:0] EcodeAdef = 6'h08;
    localparam logic [5:0] EcodeIne  = 6'h0D;
    localparam logic [5:0] EcodeSys  = 6'h0B;
    localparam logic [5:0] EcodeBrk  = 6'h0C;
    localparam logic [5:0] EcodeAle  = 6'h09;

    localparam logic [7:0] EsubcodeNone = 8'h00;

    typedef enum logic [0:0] {
        StIdle,
        StRedir
    } commit_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: INT > ADEF > INE > SYS > BRK > ALE.
module exc_prio_enc
    import exc_commit_pkg::*;
(
    input  logic            int_pend,
    input  logic [ExcW-1:0] exc,
    output logic [5:0]      ecode,
    output logic [7:0]      esubcode,
    output logic            sel_ale,
    output logic            sel_adef
);

    // Pick the highest-priority pending cause; INT code is the fallback.
    always_comb begin
        ecode    = EcodeInt;
        esubcode = EsubcodeNone;
        sel_ale  = 1'b0;
        sel_adef = 1'b0;
        if (int_pend) begin
            ecode = EcodeInt;
        end else if (exc[ExcAdef]) begin
            ecode    = EcodeAdef;
            sel_adef = 1'b1;
        end else if (exc[ExcIne]) begin
            ecode = EcodeIne;
        end else if (exc[ExcSys]) begin
            ecode = EcodeSys;
        end else if (exc[ExcBrk]) begin
            ecode = EcodeBrk;
        end else if (exc[ExcAle]) begin
            ecode   = EcodeAle;
            sel_ale = 1'b1;
        end
    end

endmodule

// File: rtl/exc_commit.sv
// Commits exceptions/interrupts/ERTN at WB, flushes the pipeline and redirects fetch.
module exc_commit
    import exc_commit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wb_valid,
    input  logic [31:0]     wb_pc,
    input  logic [ExcW-1:0] wb_exc,
    input  logic            wb_ertn,
    input  logic [31:0]     wb_vaddr,
    input  logic [12:0]     csr_estat_is,
    input  logic [12:0]     csr_ecfg_lie,
    input  logic            csr_crmd_ie,
    input  logic [31:0]     csr_eentry,
    input  logic [31:0]     csr_era,
    output logic            ex_valid,
    output logic [5:0]      ex_ecode,
    output logic [7:0]      ex_esubcode,
    output logic [31:0]     ex_pc,
    output logic [31:0]     ex_badv,
    output logic            ertn_flush,
    output logic            flush,
    output logic            redir_valid,
    output logic [31:0]     redir_pc,
    input  logic            redir_ready,
    output logic            wb_commit
);

    commit_state_e state_q, state_d;
    logic          int_pend_q, int_pend_d;
    logic [31:0]   redir_pc_q, redir_pc_d;

    logic          event_cyc;
    logic          exc_any;
    logic [5:0]    prio_ecode;
    logic [7:0]    prio_esubcode;
    logic          sel_ale;
    logic          sel_adef;

    exc_prio_enc u_prio (
        .int_pend (int_pend_q),
        .exc      (wb_exc),
        .ecode    (prio_ecode),
        .esubcode (prio_esubcode),
        .sel_ale  (sel_ale),
        .sel_adef (sel_adef)
    );

    // State, interrupt sample and redirect target registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            int_pend_q <= 1'b0;
            redir_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            int_pend_q <= int_pend_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    // Event detection, next-state logic and all combinational outputs.
    always_comb begin
        int_pend_d = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
        exc_any    = int_pend_q | (|wb_exc);
        event_cyc  = (state_q == StIdle) & wb_valid & (exc_any | wb_ertn);

        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            StIdle: begin
                if (event_cyc) begin
                    state_d    = StRedir;
                    redir_pc_d = exc_any ? csr_eentry : csr_era;
                end
            end
            StRedir: begin
                if (redir_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Report fields read as zero whenever no exception is committed.
        ex_valid    = event_cyc & exc_any;
        ex_ecode    = ex_valid ? prio_ecode : 6'h00;
        ex_esubcode = ex_valid ? prio_esubcode : 8'h00;
        ex_pc       = ex_valid ? wb_pc : 32'h0;
        ex_badv     = 32'h0;
        if (ex_valid && sel_adef) begin
            ex_badv = wb_pc;
        end else if (ex_valid && sel_ale) begin
            ex_badv = wb_vaddr;
        end

        ertn_flush  = event_cyc & wb_ertn & ~exc_any;
        redir_valid = (state_q == StRedir);
        redir_pc    = redir_pc_q;
        flush       = event_cyc | redir_valid;
        wb_commit   = wb_valid & (state_q == StIdle) & ~ex_valid;
    end

endmodule

// File: tb/tb_exc_commit.sv
// Self-checking bench for exc_commit: directed scenarios plus random traffic vs a reference model.
module tb_exc_commit;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk;
    logic        resetn;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_exc;
    logic        wb_ertn;
    logic [31:0] wb_vaddr;
    logic [12:0] csr_estat_is;
    logic [12:0] csr_ecfg_lie;
    logic        csr_crmd_ie;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        ex_valid;
    logic [5:0]  ex_ecode;
    logic [7:0]  ex_esubcode;
    logic [31:0] ex_pc;
    logic [31:0] ex_badv;
    logic        ertn_flush;
    logic        flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        wb_commit;

    exc_commit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .wb_exc       (wb_exc),
        .wb_ertn      (wb_ertn),
        .wb_vaddr     (wb_vaddr),
        .csr_estat_is (csr_estat_is),
        .csr_ecfg_lie (csr_ecfg_lie),
        .csr_crmd_ie  (csr_crmd_ie),
        .csr_eentry   (csr_eentry),
        .csr_era      (csr_era),
        .ex_valid     (ex_valid),
        .ex_ecode     (ex_ecode),
        .ex_esubcode  (ex_esubcode),
        .ex_pc        (ex_pc),
        .ex_badv      (ex_badv),
        .ertn_flush   (ertn_flush),
        .flush        (flush),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .redir_ready  (redir_ready),
        .wb_commit    (wb_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending interrupt sample, redirect in progress, latched target.
    bit          m_pend;
    bit          m_redir;
    logic [31:0] m_rpc;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, fld, obs, exp);
        end
    endtask

    function automatic bit model_event();
        return !m_redir && wb_valid && (m_pend || (wb_exc != 5'b0) || wb_ertn);
    endfunction

    // Compare every DUT output with what the rules say for the current inputs.
    task automatic check_all(input string tag);
        bit          ev, exc;
        logic [5:0]  code;
        logic [31:0] badv;
        ev   = model_event();
        exc  = m_pend || (wb_exc != 5'b0);
        code = 6'h00;
        badv = 32'h0;
        if (m_pend)         code = 6'h00;
        else if (wb_exc[0]) begin code = 6'h08; badv = wb_pc; end
        else if (wb_exc[1]) code = 6'h0D;
        else if (wb_exc[2]) code = 6'h0B;
        else if (wb_exc[3]) code = 6'h0C;
        else if (wb_exc[4]) begin code = 6'h09; badv = wb_vaddr; end
        chk(tag, "ex_valid", {31'b0, ex_valid}, {31'b0, ev && exc});
        if (ev && exc) begin
            chk(tag, "ex_ecode", {26'b0, ex_ecode}, {26'b0, code});
            chk(tag, "ex_esubcode", {24'b0, ex_esubcode}, 32'h0);
            chk(tag, "ex_pc", ex_pc, wb_pc);
            chk(tag, "ex_badv", ex_badv, badv);
        end
        chk(tag, "ertn_flush", {31'b0, ertn_flush}, {31'b0, ev && wb_ertn && !exc});
        chk(tag, "flush", {31'b0, flush}, {31'b0, ev || m_redir});
        chk(tag, "redir_valid", {31'b0, redir_valid}, {31'b0, m_redir});
        chk(tag, "redir_pc", redir_pc, m_rpc);
        chk(tag, "wb_commit", {31'b0, wb_commit},
            {31'b0, wb_valid && !m_redir && !(ev && exc)});
    endtask

    task automatic model_update();
        bit ev;
        if (!resetn) return;
        ev = model_event();
        if (ev) begin
            m_redir = 1'b1;
            m_rpc   = (m_pend || (wb_exc != 5'b0)) ? csr_eentry : csr_era;
        end else if (m_redir && redir_ready) begin
            m_redir = 1'b0;
        end
        m_pend = csr_crmd_ie && ((csr_estat_is & csr_ecfg_lie) != 13'b0);
    endtask

    // One clock: check mid-cycle, advance model on the edge, return just after it.
    task automatic tick(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_pc = 32'h0; wb_exc = 5'b0; wb_ertn = 1'b0; wb_vaddr = 32'h0;
        csr_estat_is = 13'b0; csr_ecfg_lie = 13'b0; csr_crmd_ie = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_redir = 1'b0; m_rpc = RESET_PC;
    endtask

    logic [31:0] held_pc;

    initial begin
        idle_inputs();
        csr_eentry = 32'h1c008000; csr_era = 32'h1c000100; redir_ready = 1'b1;
        resetn = 1'b0;
        model_reset();
        #12;
        chk("reset", "redir_valid", {31'b0, redir_valid}, 32'h0);
        chk("reset", "redir_pc", redir_pc, 32'h1c000000);
        chk("reset", "flush", {31'b0, flush}, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        tick("post_reset");

        // SYS exception
        wb_valid = 1'b1; wb_exc = 5'b00100; wb_pc = 32'h1c000040;
        @(negedge clk);
        chk("sys", "ex_ecode_const", {26'b0, ex_ecode}, 32'h0B);
        chk("sys", "wb_commit_const", {31'b0, wb_commit}, 32'h0);
        check_all("sys");
        @(posedge clk); model_update(); #1;
        idle_inputs();
        @(negedge clk);
        chk("sys_redir", "redir_pc_const", redir_pc, 32'h1c008000);
        chk("sys_redir", "ex_valid_once", {31'b0, ex_valid}, 32'h0);
        check_all("sys_redir");
        @(posedge clk); model_update(); #1;
        tick("sys_idle");

        // ADEF outranks ALE
        wb_valid = 1'b1; wb_exc = 5'b10001; wb_pc = 32'h1c000080; wb_vaddr = 32'hdead0004;
        @(negedge clk);
        chk("adef", "ex_ecode_const", {26'b0, ex_ecode}, 32'h08);
        chk("adef", "ex_badv_const", ex_badv, 32'h1c000080);
        check_all("adef");
        @(posedge clk); model_update(); #1;
        idle_inputs(); tick("adef_redir"); tick("adef_idle");

        // ALE alone reports the data address
        wb_valid = 1'b1; wb_exc = 5'b10000; wb_pc = 32'h1c0000c0; wb_vaddr = 32'h00001003;
        tick("ale");
        idle_inputs(); tick("ale_redir"); tick("ale_idle");

        // ERTN without exception
        wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1c000200;
        @(negedge clk);
        chk("ertn", "ertn_flush_const", {31'b0, ertn_flush}, 32'h1);
        check_all("ertn");
        @(posedge clk); model_update(); #1;
        idle_inputs();
        @(negedge clk);
        chk("ertn_redir", "redir_pc_const", redir_pc, 32'h1c000100);
        check_all("ertn_redir");
        @(posedge clk); model_update(); #1;
        tick("ertn_idle");

        // ERTN with INE: exception wins
        wb_valid = 1'b1; wb_ertn = 1'b1; wb_exc = 5'b00010; wb_pc = 32'h1c000204;
        @(negedge clk);
        chk("ertn_ine", "ex_ecode_const", {26'b0, ex_ecode}, 32'h0D);
        chk("ertn_ine", "ertn_flush_const", {31'b0, ertn_flush}, 32'h0);
        check_all("ertn_ine");
        @(posedge clk); model_update(); #1;
        idle_inputs(); tick("ertn_ine_redir"); tick("ertn_ine_idle");

        // Interrupt outranks SYS
        csr_crmd_ie = 1'b1; csr_estat_is = 13'h800; csr_ecfg_lie = 13'h800;
        tick("int_sample");
        wb_valid = 1'b1; wb_exc = 5'b00100; wb_pc = 32'h1c000300;
        @(negedge clk);
        chk("int", "ex_ecode_const", {26'b0, ex_ecode}, 32'h00);
        check_all("int");
        @(posedge clk); model_update(); #1;
        idle_inputs(); tick("int_redir"); tick("int_idle"); tick("int_quiet");

        // Redirect back-pressure: held target, ignored WB events
        redir_ready = 1'b0;
        wb_valid = 1'b1; wb_exc = 5'b01000; wb_pc = 32'h1c000400; csr_eentry = 32'h1c00a000;
        tick("bp_event");
        held_pc = redir_pc;
        csr_eentry = 32'h1c00b000; csr_era = 32'h1c00c000;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; wb_exc = 5'(i + 1); wb_ertn = 1'b1;
            tick("bp_hold");
            chk("bp_hold", "redir_pc_stable", redir_pc, held_pc);
        end
        idle_inputs(); redir_ready = 1'b1;
        tick("bp_release");
        tick("bp_idle");

        // Reset in the middle of a redirect
        wb_valid = 1'b1; wb_exc = 5'b00100; wb_pc = 32'h1c000500; redir_ready = 1'b0;
        tick("rst_event");
        idle_inputs();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_mid", "redir_valid", {31'b0, redir_valid}, 32'h0);
        chk("rst_mid", "redir_pc", redir_pc, 32'h1c000000);
        tick("rst_hold");
        resetn = 1'b1; redir_ready = 1'b1;
        tick("rst_rel0");
        tick("rst_rel1");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            wb_valid     = ($urandom_range(0, 3) != 0);
            wb_pc        = $urandom;
            wb_vaddr     = $urandom;
            wb_exc       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            wb_ertn      = ($urandom_range(0, 5) == 0);
            csr_crmd_ie  = ($urandom_range(0, 1) == 1);
            csr_estat_is = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'b0;
            csr_ecfg_lie = 13'($urandom);
            csr_eentry   = $urandom;
            csr_era      = $urandom;
            redir_ready  = ($urandom_range(0, 2) != 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, the value redir_pc holds after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_valid  input  1  WB stage holds a valid instruction this cycle.
REQ-005 SHALL have port wb_pc  input  32  PC of the WB instruction.
REQ-006 SHALL have port wb_exc  input  5  per-instruction exception flags, bit 0 ADEF, 1 INE, 2 SYS, 3 BRK, 4 ALE.
REQ-007 SHALL have port wb_ertn  input  1  the WB instruction is ERTN.
REQ-008 SHALL have port wb_vaddr  input  32  data address of the WB load/store.
REQ-009 SHALL have ports csr_estat_is  input  13, csr_ecfg_lie  input  13, csr_crmd_ie  input  1  interrupt state from CSR.
REQ-010 SHALL have ports csr_eentry  input  32, csr_era  input  32  exception entry and return address.
REQ-011 SHALL have ports ex_valid  output  1, ex_ecode  output  6, ex_esubcode  output  8, ex_pc  output  32, ex_badv  output  32, ertn_flush  output  1  commit of an exception or ERTN into CSR.
REQ-012 SHALL have port flush  output  1  kill all pipeline stages.
REQ-013 SHALL have ports redir_valid  output  1, redir_pc  output  32, redir_ready  input  1  fetch redirect handshake.
REQ-014 SHALL have port wb_commit  output  1  WB instruction may write the register file.

Function
REQ-015 SHALL register int_pend_q <= csr_crmd_ie & |(csr_estat_is & csr_ecfg_lie) every cycle.
REQ-016 SHALL define event cycle = state IDLE & wb_valid & (int_pend_q | |wb_exc | wb_ertn).
REQ-017 SHALL select the exception by fixed priority INT > ADEF > INE > SYS > BRK > ALE; ecode/esubcode: INT 0x00/0, ADEF 0x08/0, INE 0x0D/0, SYS 0x0B/0, BRK 0x0C/0, ALE 0x09/0.
REQ-018 SHALL assert ex_valid combinationally for exactly the event cycle when any exception or interrupt is selected; ex_pc = wb_pc.
REQ-019 SHALL drive ex_badv = wb_pc for ADEF, wb_vaddr for ALE, 0 otherwise.
REQ-020 SHALL assert ertn_flush in an event cycle only when wb_ertn and no exception/interrupt is selected (exception wins).
REQ-021 SHALL assert flush in the event cycle and every cycle in state REDIR.
REQ-022 SHALL have states IDLE, REDIR: IDLE->REDIR on event cycle; REDIR->IDLE on redir_valid & redir_ready; otherwise hold.
REQ-023 SHALL latch redir_pc on the event edge: csr_eentry for exception/interrupt, csr_era for ERTN; redir_valid = (state==REDIR).
REQ-024 SHALL hold redir_pc stable while redir_valid & ~redir_ready.
REQ-025 SHALL ignore wb_valid, wb_exc, wb_ertn in REDIR (no ex_valid, no ertn_flush).
REQ-026 SHALL drive wb_commit = wb_valid & state IDLE & ~ex_valid.
REQ-027 SHALL, with redir_ready held high, spend exactly one cycle in REDIR (event at edge N, redir_valid high N..N+1, IDLE at N+1).

Reset
REQ-028 SHALL on resetn low, asynchronously: state IDLE, int_pend_q 0, redir_valid 0, redir_pc RESET_PC; combinational outputs therefore 0.
REQ-029 SHALL abandon an in-progress REDIR on reset with no redirect issued.

Structure
REQ-030 SHALL place ecode/esubcode constants, wb_exc bit indices and the state enum in the shared CPU package used by CSR.
REQ-031 SHALL implement priority selection in one sub-module exc_prio_enc (flags in, ecode/esubcode/sel_ale/sel_adef out, purely combinational).

Verification
REQ-032 SHALL cover: wb_valid=1, wb_exc=5'b00100, wb_pc=0x1c000040, eentry=0x1c008000 -> ex_valid 1 cycle, ecode 0x0B, redir_pc 0x1c008000, wb_commit 0.
REQ-033 SHALL cover: wb_exc=5'b10001, wb_pc=0x1c000080 -> ecode 0x08, esubcode 0, ex_badv 0x1c000080 (ADEF over ALE).
REQ-034 SHALL cover: wb_ertn=1, era=0x1c000100, no exc -> ertn_flush 1, ex_valid 0, redir_pc 0x1c000100; with wb_exc=5'b00010 also set -> ex_valid, ecode 0x0D, ertn_flush 0.
REQ-035 SHALL cover: ie=1, estat_is[11]=1, lie[11]=1 -> next valid WB instruction gets ecode 0x00 even with wb_exc=5'b00100.
REQ-036 SHALL cover: redir_ready low 3 cycles -> redir_valid and flush held 3+ cycles, redir_pc constant, new wb events ignored; IDLE one cycle after ready.
REQ-037 SHALL cover: resetn low mid-REDIR -> redir_valid 0 immediately, redir_pc 0x1c000000, no ex_valid after release.
